// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor step per cycle, LSB first, IDLE/RUN/DONE control.
// Optional SERIAL_SUB_SAT_EN clamps d to zero when the final borrow is set.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_next_c;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             diff_c, br_next_c, last_c;

  // One full-subtractor step on the current operand LSBs
  always_comb begin
    diff_c     = a_sr[0] ^ b_sr[0] ^ br;
    br_next_c  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_next_c = WIDTH'({diff_c, res_sr} >> 1);
    last_c     = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            cnt  <= '0;
            br   <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next_c;
          br     <= br_next_c;
          cnt    <= cnt + CW'(1);
          if (last_c) begin
`ifdef SERIAL_SUB_SAT_EN
            d      <= br_next_c ? '0 : res_next_c;
`else
            d      <= res_next_c;
`endif
            borrow <= br_next_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
